// File: rtl/adc_scan_sequencer_if.sv
// Signal bundle linking the scan sequencer to the SPI ADC master, the scan
// controls and the downstream sample consumer.
interface adc_scan_sequencer_if #(
    parameter int NUM_CH  = 8,
    parameter int CH_BITS = 3
);
    logic               START;
    logic               CONT;
    logic [NUM_CH-1:0]  CH_MASK;
    logic               ERR_CLR;
    logic               ADC_ENA;
    logic [15:0]        ADC_DATA_MOSI;
    logic               ADC_FIN;
    logic [15:0]        ADC_DATA_MISO;
    logic [11:0]        SAMPLE;
    logic [CH_BITS-1:0] SAMPLE_CH;
    logic               SAMPLE_VALID;
    logic               BUSY;
    logic               ERR;

    modport master (
        input  START, CONT, CH_MASK, ERR_CLR, ADC_FIN, ADC_DATA_MISO,
        output ADC_ENA, ADC_DATA_MOSI, SAMPLE, SAMPLE_CH, SAMPLE_VALID, BUSY, ERR
    );

    modport slave (
        output START, CONT, CH_MASK, ERR_CLR, ADC_FIN, ADC_DATA_MISO,
        input  ADC_ENA, ADC_DATA_MOSI, SAMPLE, SAMPLE_CH, SAMPLE_VALID, BUSY, ERR
    );
endinterface

// File: rtl/adc_scan_sequencer.sv
// Scans a masked set of ADC channels through the SPI ADC master and re-tags
// each returned sample with the channel that produced it (one-frame lag).
module adc_scan_sequencer #(
    parameter int NUM_CH     = 8,
    parameter int CH_BITS    = 3,
    parameter int ADDR_LSB   = 11,
    parameter int GAP_CYCLES = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                 SYS_CLK,
    input  logic                 RST,
    adc_scan_sequencer_if.master bus
);

    localparam int CNT_MAX = (GAP_CYCLES > TIMEOUT) ? GAP_CYCLES : TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GAP,
        S_XFER,
        S_CAPTURE,
        S_RELEASE
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_CH-1:0]    mask_q, mask_d;
    logic [CH_BITS-1:0]   cur_ch_q, cur_ch_d;
    logic [CH_BITS-1:0]   prev_ch_q, prev_ch_d;
    logic                 prev_valid_q, prev_valid_d;
    logic                 cont_q, cont_d;
    logic                 last_q, last_d;
    logic                 done_q, done_d;
    logic                 abort_q, abort_d;
    logic                 ena_q, ena_d;
    logic [15:0]          mosi_q, mosi_d;
    logic [11:0]          sample_q, sample_d;
    logic [CH_BITS-1:0]   sample_ch_q, sample_ch_d;
    logic                 sample_valid_q, sample_valid_d;
    logic                 err_q, err_d;
    logic                 fin_meta_q, fin_meta_d;
    logic                 fin_s_q, fin_s_d;
    logic                 timeout;
    logic [CH_BITS:0]     nxt;

    function automatic logic [CH_BITS-1:0] lowest_ch(input logic [NUM_CH-1:0] m);
        lowest_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i]) lowest_ch = CH_BITS'(i);
        end
    endfunction

    // {found, index} of the lowest enabled channel strictly above cur
    function automatic logic [CH_BITS:0] next_above(input logic [NUM_CH-1:0] m,
                                                    input logic [CH_BITS-1:0] cur);
        next_above = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i] && (i > int'(cur))) next_above = {1'b1, CH_BITS'(i)};
        end
    endfunction

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        mask_d         = mask_q;
        cur_ch_d       = cur_ch_q;
        prev_ch_d      = prev_ch_q;
        prev_valid_d   = prev_valid_q;
        cont_d         = cont_q;
        last_d         = last_q;
        done_d         = done_q;
        abort_d        = abort_q;
        ena_d          = ena_q;
        mosi_d         = mosi_q;
        sample_d       = sample_q;
        sample_ch_d    = sample_ch_q;
        sample_valid_d = 1'b0;
        err_d          = err_q;
        timeout        = 1'b0;
        fin_meta_d     = bus.ADC_FIN;
        fin_s_d        = fin_meta_q;
        nxt            = next_above(mask_q, cur_ch_q);

        case (state_q)
            S_IDLE: begin
                ena_d = 1'b0;
                if (bus.START && (bus.CH_MASK != '0)) begin
                    mask_d       = bus.CH_MASK;
                    cur_ch_d     = lowest_ch(bus.CH_MASK);
                    prev_valid_d = 1'b0;
                    cont_d       = bus.CONT;
                    last_d       = 1'b0;
                    done_d       = 1'b0;
                    abort_d      = 1'b0;
                    cnt_d        = '0;
                    state_d      = S_GAP;
                end
            end

            S_GAP: begin
                // The command word is only ever updated here, with ENA low.
                ena_d  = 1'b0;
                mosi_d = 16'(cur_ch_q) << ADDR_LSB;
                if (cnt_q != CNT_W'(GAP_CYCLES)) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (abort_q) begin
                    state_d = S_IDLE;
                end else if (!fin_s_q) begin
                    ena_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_XFER;
                end
            end

            S_XFER: begin
                if (fin_s_q) begin
                    // Result of this frame belongs to the previously addressed channel.
                    sample_d     = bus.ADC_DATA_MISO[11:0];
                    if (prev_valid_q) begin
                        sample_valid_d = 1'b1;
                        sample_ch_d    = prev_ch_q;
                    end
                    prev_ch_d    = cur_ch_q;
                    prev_valid_d = 1'b1;
                    if (last_q) begin
                        done_d = 1'b1;
                    end else if (cont_q && !bus.CONT) begin
                        done_d = 1'b1;
                    end else if (nxt[CH_BITS]) begin
                        cur_ch_d = nxt[CH_BITS-1:0];
                    end else if (cont_q) begin
                        if (bus.CH_MASK == '0) begin
                            done_d = 1'b1;
                        end else begin
                            mask_d   = bus.CH_MASK;
                            cur_ch_d = lowest_ch(bus.CH_MASK);
                        end
                    end else begin
                        // Single pass: one dummy frame re-addressing the first channel.
                        last_d   = 1'b1;
                        cur_ch_d = lowest_ch(mask_q);
                    end
                    state_d = S_CAPTURE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    timeout = 1'b1;
                    ena_d   = 1'b0;
                    abort_d = 1'b1;
                    cnt_d   = '0;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_CAPTURE: begin
                ena_d   = 1'b0;
                cnt_d   = '0;
                state_d = S_RELEASE;
            end

            S_RELEASE: begin
                ena_d = 1'b0;
                if (!fin_s_q) begin
                    cnt_d   = '0;
                    state_d = done_q ? S_IDLE : S_GAP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    timeout = 1'b1;
                    abort_d = 1'b1;
                    cnt_d   = '0;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                ena_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        // A timeout in the same cycle overrides a clear request.
        if (bus.ERR_CLR) err_d = 1'b0;
        if (timeout)     err_d = 1'b1;
    end

    always_ff @(posedge SYS_CLK or posedge RST) begin
        if (RST) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            mask_q         <= '0;
            cur_ch_q       <= '0;
            prev_ch_q      <= '0;
            prev_valid_q   <= 1'b0;
            cont_q         <= 1'b0;
            last_q         <= 1'b0;
            done_q         <= 1'b0;
            abort_q        <= 1'b0;
            ena_q          <= 1'b0;
            mosi_q         <= '0;
            sample_q       <= '0;
            sample_ch_q    <= '0;
            sample_valid_q <= 1'b0;
            err_q          <= 1'b0;
            fin_meta_q     <= 1'b0;
            fin_s_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            mask_q         <= mask_d;
            cur_ch_q       <= cur_ch_d;
            prev_ch_q      <= prev_ch_d;
            prev_valid_q   <= prev_valid_d;
            cont_q         <= cont_d;
            last_q         <= last_d;
            done_q         <= done_d;
            abort_q        <= abort_d;
            ena_q          <= ena_d;
            mosi_q         <= mosi_d;
            sample_q       <= sample_d;
            sample_ch_q    <= sample_ch_d;
            sample_valid_q <= sample_valid_d;
            err_q          <= err_d;
            fin_meta_q     <= fin_meta_d;
            fin_s_q        <= fin_s_d;
        end
    end

    assign bus.ADC_ENA       = ena_q;
    assign bus.ADC_DATA_MOSI = mosi_q;
    assign bus.SAMPLE        = sample_q;
    assign bus.SAMPLE_CH     = sample_ch_q;
    assign bus.SAMPLE_VALID  = sample_valid_q;
    assign bus.BUSY          = (state_q != S_IDLE);
    assign bus.ERR           = err_q;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Bench for adc_scan_sequencer: a behavioural SPI ADC drives random frames and
// a list-based model of the scan order predicts command words and tagged samples.
module tb_adc_scan_sequencer;

    localparam int NUM_CH     = 8;
    localparam int CH_BITS    = 3;
    localparam int ADDR_LSB   = 11;
    localparam int GAP_CYCLES = 8;
    localparam int TIMEOUT    = 255;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    adc_scan_sequencer_if #(.NUM_CH(NUM_CH), .CH_BITS(CH_BITS)) bus ();

    adc_scan_sequencer #(
        .NUM_CH(NUM_CH), .CH_BITS(CH_BITS), .ADDR_LSB(ADDR_LSB),
        .GAP_CYCLES(GAP_CYCLES), .TIMEOUT(TIMEOUT)
    ) dut (
        .SYS_CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_fin_cyc = 0;
    bit adc_respond  = 1'b1;

    logic [15:0] fa[$];       // command word seen at each ENA rise
    logic [11:0] fd[$];       // result returned by each completed frame
    logic [15:0] preset[$];   // optional forced MISO words
    logic [2:0]  got_ch[$];
    logic [11:0] got_val[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Behavioural SPI ADC master: FIN after a random conversion time, held until ENA drops.
    initial begin : adc_model
        logic [15:0] w;
        int lat;
        bit aborted;
        bus.ADC_FIN       = 1'b0;
        bus.ADC_DATA_MISO = '0;
        forever begin
            @(posedge bus.ADC_ENA);
            fa.push_back(bus.ADC_DATA_MOSI);
            lat = $urandom_range(4, 20);
            aborted = 1'b0;
            for (int j = 0; j < lat; j++) begin
                @(negedge clk);
                if (!bus.ADC_ENA) begin
                    aborted = 1'b1;
                    break;
                end
            end
            if (!aborted && adc_respond) begin
                if (preset.size() > 0) w = preset.pop_front();
                else w = 16'($urandom);
                bus.ADC_DATA_MISO = w;
                bus.ADC_FIN = 1'b1;
                last_fin_cyc = cyc;
                fd.push_back(w[11:0]);
                while (bus.ADC_ENA) @(negedge clk);
                repeat ($urandom_range(1, 12)) @(negedge clk);
                bus.ADC_FIN = 1'b0;
            end else begin
                while (bus.ADC_ENA) @(negedge clk);
            end
        end
    end

    initial begin : monitor
        bit prev_v;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && bus.SAMPLE_VALID) begin
                got_ch.push_back(bus.SAMPLE_CH);
                got_val.push_back(bus.SAMPLE);
                check("valid_latency", cyc - last_fin_cyc, 3);
                check("valid_width", prev_v, 0);
            end
            prev_v = bus.SAMPLE_VALID;
        end
    end

    task automatic clear_logs();
        fa.delete();
        fd.delete();
        got_ch.delete();
        got_val.delete();
    endtask

    // Runs one scan (called at a negedge) and compares against the channel-list model.
    task automatic do_scan(input logic [7:0] m, input bit cont, input int n_cont, input bit restart);
        int en[$];
        int k;
        int e;
        int nexp;
        clear_logs();
        for (int i = 0; i < NUM_CH; i++) if (m[i]) en.push_back(i);
        e = en.size();
        bus.CH_MASK = m;
        bus.CONT    = cont;
        bus.START   = 1'b1;
        @(negedge clk);
        bus.START = 1'b0;
        k = 0;
        while (!bus.ADC_ENA && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("ena_rise_edges", k, GAP_CYCLES + 1);
        if (restart) begin
            bus.CH_MASK = 8'hFF;
            bus.START   = 1'b1;
            @(negedge clk);
            bus.START = 1'b0;
        end
        if (cont) begin
            k = 0;
            while (fa.size() < n_cont && k < 3000) begin
                @(negedge clk);
                k++;
            end
            bus.CONT = 1'b0;
        end
        k = 0;
        while (bus.BUSY && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check("scan_ends_idle", bus.BUSY, 0);
        check("scan_err", bus.ERR, 0);
        nexp = cont ? n_cont : e + 1;
        check("frame_count", fa.size(), nexp);
        for (int i = 0; i < nexp && i < fa.size(); i++)
            check("cmd_word", fa[i], 16'(en[i % e]) << ADDR_LSB);
        check("sample_count", got_ch.size(), nexp - 1);
        for (int i = 0; i < nexp - 1 && i < got_ch.size(); i++) begin
            check("sample_ch", got_ch[i], en[i % e]);
            if (i + 1 < fd.size()) check("sample_val", got_val[i], fd[i + 1]);
        end
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int k;
        int n_hi;
        int n_busy;
        rst         = 1'b1;
        bus.START   = 1'b0;
        bus.CONT    = 1'b0;
        bus.CH_MASK = '0;
        bus.ERR_CLR = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ena", bus.ADC_ENA, 0);
        check("rst_mosi", bus.ADC_DATA_MOSI, 0);
        check("rst_sample", bus.SAMPLE, 0);
        check("rst_sample_ch", bus.SAMPLE_CH, 0);
        check("rst_valid", bus.SAMPLE_VALID, 0);
        check("rst_busy", bus.BUSY, 0);
        check("rst_err", bus.ERR, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Directed: channels 0 and 2, second frame returns 0x0ABC.
        preset = '{16'h3111, 16'h0ABC, 16'hE222};
        do_scan(8'h05, 1'b0, 0, 1'b0);
        if (got_val.size() == 2) begin
            check("dir_val0", got_val[0], 12'hABC);
            check("dir_ch0", got_ch[0], 0);
            check("dir_val1", got_val[1], 12'h222);
            check("dir_ch1", got_ch[1], 2);
        end
        @(negedge clk);

        for (int t = 0; t < 5; t++) begin
            do_scan(8'($urandom_range(1, 255)), 1'b0, 0, 1'b0);
            @(negedge clk);
        end
        do_scan(8'h40, 1'b0, 0, 1'b0);
        @(negedge clk);

        do_scan(8'h81, 1'b1, 5, 1'b0);
        @(negedge clk);
        do_scan(8'h08, 1'b1, 4, 1'b0);
        @(negedge clk);
        for (int t = 0; t < 2; t++) begin
            do_scan(8'($urandom_range(1, 255)), 1'b1, $urandom_range(2, 9), 1'b0);
            @(negedge clk);
        end

        // START with an empty mask must be ignored.
        clear_logs();
        bus.CH_MASK = '0;
        bus.START   = 1'b1;
        @(negedge clk);
        bus.START = 1'b0;
        n_hi = 0;
        n_busy = 0;
        for (int i = 0; i < 30; i++) begin
            if (bus.ADC_ENA) n_hi++;
            if (bus.BUSY) n_busy++;
            @(negedge clk);
        end
        check("empty_mask_ena", n_hi, 0);
        check("empty_mask_busy", n_busy, 0);

        // START while busy with a different mask must not disturb the scan.
        do_scan(8'h24, 1'b0, 0, 1'b1);
        @(negedge clk);

        // Timeout: the ADC never answers.
        clear_logs();
        adc_respond = 1'b0;
        bus.CH_MASK = 8'h10;
        bus.CONT    = 1'b0;
        bus.START   = 1'b1;
        @(negedge clk);
        bus.START = 1'b0;
        n_hi = 0;
        k = 0;
        while (!bus.ERR && k < 600) begin
            if (bus.ADC_ENA) n_hi++;
            @(negedge clk);
            k++;
        end
        check("to_err", bus.ERR, 1);
        check("to_ena_cycles", n_hi, TIMEOUT);
        check("to_ena_low", bus.ADC_ENA, 0);
        k = 0;
        while (bus.BUSY && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("to_idle", bus.BUSY, 0);
        check("to_no_sample", got_ch.size(), 0);
        check("to_err_sticky", bus.ERR, 1);
        bus.ERR_CLR = 1'b1;
        @(negedge clk);
        bus.ERR_CLR = 1'b0;
        check("err_clr", bus.ERR, 0);
        adc_respond = 1'b1;
        repeat (2) @(negedge clk);

        // Asynchronous reset in the middle of a transfer.
        clear_logs();
        bus.CH_MASK = 8'h0C;
        bus.START   = 1'b1;
        @(negedge clk);
        bus.START = 1'b0;
        k = 0;
        while (!bus.ADC_ENA && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("rst_pre_ena", bus.ADC_ENA, 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_ena", bus.ADC_ENA, 0);
        check("arst_mosi", bus.ADC_DATA_MOSI, 0);
        check("arst_sample", bus.SAMPLE, 0);
        check("arst_sample_ch", bus.SAMPLE_CH, 0);
        check("arst_valid", bus.SAMPLE_VALID, 0);
        check("arst_busy", bus.BUSY, 0);
        check("arst_err", bus.ERR, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        do_scan(8'($urandom_range(1, 255)), 1'b0, 0, 1'b0);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adc_scan_sequencer.md
Name: adc_scan_sequencer

Overview:
- Sequences the 16-bit SPI ADC master (SYS_CLK/4 serial clock, ENA/FIN handshake) to scan a masked set of ADC channels, single-pass or continuous.
- Builds each command word and drives ENA, then waits for FIN through a synchroniser.
- Undoes the ADC's one-frame result pipeline: each returned sample is tagged with the channel that produced it.
- Sits between the SPI master and the downstream sample consumer (ranging/filter logic).

Parameters:
- NUM_CH, 8: channels available; width of CH_MASK.
- CH_BITS, 3: channel index width; log2(NUM_CH).
- ADDR_LSB, 11: bit position of the channel address inside the 16-bit command word.
- GAP_CYCLES, 8: SYS_CLK cycles ENA stays low between frames. Must be at least 4 (one SPI_CLK period).
- TIMEOUT, 255: maximum SYS_CLK cycles allowed in XFER or RELEASE before abort.

Ports:
- SYS_CLK  in  1  system clock
- RST  in  1  reset, asynchronous, active-high
- START  in  1  scan request, sampled high for one cycle while idle
- CONT  in  1  1 = continuous scanning, 0 = single pass
- CH_MASK  in  NUM_CH  enabled channels
- ERR_CLR  in  1  clears ERR
- ADC_ENA  out  1  to the SPI master ENA input
- ADC_DATA_MOSI  out  16  command word to the SPI master
- ADC_FIN  in  1  SPI master FIN (launched from the SPI_CLK domain)
- ADC_DATA_MISO  in  16  SPI master result
- SAMPLE  out  12  conversion result, ADC_DATA_MISO[11:0]
- SAMPLE_CH  out  CH_BITS  channel that produced SAMPLE
- SAMPLE_VALID  out  1  one-cycle strobe qualifying SAMPLE and SAMPLE_CH
- BUSY  out  1  high whenever state is not IDLE
- ERR  out  1  sticky timeout flag

Behaviour:
- Reset: all outputs 0, state IDLE, synchroniser flops cleared. ADC_ENA drops asynchronously, so a frame in progress is abandoned and the SPI master resets on CSbar.
- FIN sync: ADC_FIN passes through 2 flops to give fin_s. Only fin_s is used.
- Command word: ADC_DATA_MOSI = cur_ch << ADDR_LSB, all other bits 0. It changes only in GAP, while ADC_ENA is low.
- States:
  - IDLE: START=1 and CH_MASK!=0 → latch the mask. cur_ch = lowest enabled index, prev_valid=0, go to GAP. START is ignored when CH_MASK==0 or when not IDLE.
  - GAP: ADC_ENA=0 and the counter runs GAP_CYCLES cycles. Exits to XFER only once fin_s==0, then sets ADC_ENA=1. ADC_ENA therefore rises exactly GAP_CYCLES+1 edges after the edge that sampled START.
  - XFER: ADC_ENA=1. When fin_s==1, go to CAPTURE. Timeout applies.
  - CAPTURE (1 cycle): register ADC_DATA_MISO[11:0]. If prev_valid, pulse SAMPLE_VALID with SAMPLE_CH=prev_ch. Then set prev_ch=cur_ch, prev_valid=1, and advance cur_ch to the next enabled channel ascending, wrapping NUM_CH-1→0. Go to RELEASE with ADC_ENA=0.
  - RELEASE: wait until fin_s==0, then go to GAP. Timeout applies.
- Pipelining: the result of frame k belongs to the channel addressed in frame k-1. The first frame after START is discarded (prev_valid=0).
- Single pass with E enabled channels: E+1 frames run. The last frame re-addresses the first enabled channel as a dummy. Exactly E SAMPLE_VALID pulses occur, then IDLE.
- Continuous mode: wraps indefinitely with no further discards. Mask is re-latched at each wrap; if the new mask is 0, the scan finishes as in the CONT-fall case.
- CONT falling mid-scan: the current frame completes and its sample is emitted. After RELEASE the block goes to IDLE, and the last addressed channel is not reported.
- Single-channel mask: every frame addresses the same channel, and the wrap lands on itself.
- Timeout: the counter resets on entering XFER or RELEASE. If it reaches TIMEOUT: ERR=1, ADC_ENA=0, no sample is emitted, and the block goes to IDLE after one GAP.
- ERR priority: ERR_CLR clears ERR, but a timeout in the same cycle wins.
- Latency: SAMPLE_VALID occurs 3 cycles after ADC_FIN rises (2 sync + 1 capture).

Test Plan:
- CH_MASK=8'b0000_0101, CONT=0, START pulse → 3 frames addressing ch 0, 2, 0 (MOSI 0x0000, 0x1000, 0x0000). SAMPLE_VALID×2 with SAMPLE_CH=0 then 2, then BUSY=0.
- Model returns 0x0ABC for a ch-2 frame that follows a ch-0 frame → SAMPLE=0xABC, SAMPLE_CH=0, SAMPLE_VALID high exactly 1 cycle, 3 cycles after ADC_FIN rises.
- CONT=1, mask 8'b1000_0001 → ch sequence 0, 7, 0, 7…; the wrap 7→0 is correct and samples are tagged 0, 7, 0…. Drop CONT mid-frame → that frame's sample is emitted, then IDLE.
- Hold ADC_FIN=0 during XFER → ERR=1 after 255 cycles, ADC_ENA=0, no SAMPLE_VALID, IDLE. ERR_CLR → ERR=0.
- RST asserted mid-XFER → ADC_ENA=0 asynchronously, all outputs 0. A new START is accepted afterwards.
- START with CH_MASK=0, and START while BUSY → ignored, no ADC_ENA activity.
